// File: rtl/udp_tx_frame_sink.sv
// Consumer end of the event-builder TX handshake: checks each frame against its announced
// length, buffers it in a byte FIFO and forwards whole frames to the MAC stream.
module udp_tx_frame_sink #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned MAX_LEN    = 4000,
  parameter int unsigned LENQ_LOG2  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        txreq,
  output logic        txack,
  input  logic        txstart,
  input  logic        txstop,
  input  logic        txdone,
  input  logic [7:0]  txdata,
  input  logic [15:0] txlength,
  output logic        txdstrdy,
  output logic        txendframe,
  output logic [7:0]  mac_data,
  output logic        mac_valid,
  input  logic        mac_ready,
  output logic        mac_sof,
  output logic        mac_eof,
  output logic [31:0] frame_count,
  output logic [15:0] err_count
);

  localparam int unsigned Depth     = 1 << DEPTH_LOG2;
  localparam int unsigned LenqDepth = 1 << LENQ_LOG2;
  localparam logic [15:0] MaxLen    = 16'(MAX_LEN);

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef logic [LENQ_LOG2:0]  lptr_t;

  typedef enum logic [1:0] {StIdle, StGrant, StRecv, StDrop} in_state_e;
  typedef enum logic {StMIdle, StMSend} out_state_e;

  in_state_e   in_state_q, in_state_d;
  out_state_e  out_state_q, out_state_d;
  logic        txack_q, txack_d;
  logic        txdstrdy_q, txdstrdy_d;
  logic        txendframe_q, txendframe_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovr_q, ovr_d;
  logic [15:0] err_q, err_d;
  ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
  lptr_t       lwptr_q, lwptr_d, lrptr_q, lrptr_d;
  logic [15:0] n_q, n_d;
  logic [15:0] sent_q, sent_d;
  logic        mac_valid_q, mac_valid_d;
  logic [7:0]  mac_data_q, mac_data_d;
  logic        mac_sof_q, mac_sof_d;
  logic        mac_eof_q, mac_eof_d;
  logic [31:0] frame_q, frame_d;

  logic [7:0]  mem  [Depth];
  logic [15:0] lenq [LenqDepth];

  logic        accept, fifo_we, lenq_push, end_pulse, err_inc;
  logic        lenq_empty, xfer;
  logic [15:0] lenq_head;
  logic [7:0]  rd_byte;
  ptr_t        used_d;
  lptr_t       lcnt_d;

  assign lenq_empty = (lwptr_q == lrptr_q);
  assign lenq_head  = lenq[lrptr_q[LENQ_LOG2-1:0]];
  assign rd_byte    = mem[rptr_q[DEPTH_LOG2-1:0]];
  assign xfer       = mac_valid_q && mac_ready;

  // Ingest FSM: grant handling, length check and FIFO write decisions.
  always_comb begin
    in_state_d = in_state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ovr_d      = ovr_q;
    fifo_we    = 1'b0;
    lenq_push  = 1'b0;
    end_pulse  = 1'b0;
    err_inc    = 1'b0;
    accept     = txdstrdy_q && ((in_state_q == StGrant && txstart) ||
                                in_state_q == StRecv || in_state_q == StDrop);
    unique case (in_state_q)
      StIdle: begin
        if (txreq && enable) in_state_d = StGrant;
      end
      StGrant: begin
        if (accept) begin
          len_d = txlength;
          cnt_d = 16'd0;
          ovr_d = 1'b0;
          if (txlength != 16'd0 && txlength <= MaxLen) begin
            fifo_we   = 1'b1;
            cnt_d     = 16'd1;
            end_pulse = (txlength == 16'd1);
            if (txstop) begin
              lenq_push = 1'b1;
              err_inc   = (txlength != 16'd1);
            end else begin
              in_state_d = StRecv;
            end
          end else begin
            err_inc   = 1'b1;
            end_pulse = 1'b1;
            if (!txstop) in_state_d = StDrop;
          end
        end else if (txdone) begin
          in_state_d = StIdle;
        end
      end
      StRecv: begin
        if (accept) begin
          if (cnt_q < len_q) begin
            fifo_we   = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            end_pulse = (cnt_d == len_q);
          end else begin
            ovr_d = 1'b1;
          end
          if (txstop) begin
            lenq_push  = 1'b1;
            err_inc    = (cnt_d != len_q) || ovr_d;
            in_state_d = StGrant;
          end
        end
      end
      StDrop: begin
        if (accept && txstop) in_state_d = StGrant;
      end
      default: in_state_d = StIdle;
    endcase
  end

  // Output FSM: pops a frame length, then streams exactly that many bytes.
  always_comb begin
    out_state_d = out_state_q;
    n_d         = n_q;
    sent_d      = sent_q;
    rptr_d      = rptr_q;
    lrptr_d     = lrptr_q;
    mac_valid_d = mac_valid_q;
    mac_data_d  = mac_data_q;
    mac_sof_d   = mac_sof_q;
    mac_eof_d   = mac_eof_q;
    frame_d     = frame_q;
    if (xfer) begin
      mac_valid_d = 1'b0;
      mac_sof_d   = 1'b0;
      mac_eof_d   = 1'b0;
    end
    unique case (out_state_q)
      StMIdle: begin
        if (!lenq_empty) begin
          n_d         = lenq_head;
          sent_d      = 16'd0;
          lrptr_d     = lrptr_q + lptr_t'(1);
          out_state_d = StMSend;
        end
      end
      StMSend: begin
        if (xfer && mac_eof_q) begin
          frame_d = frame_q + 32'd1;
          if (!lenq_empty) begin
            // Back-to-back frames: load the next frame's first byte straight away.
            n_d         = lenq_head;
            lrptr_d     = lrptr_q + lptr_t'(1);
            mac_data_d  = rd_byte;
            rptr_d      = rptr_q + ptr_t'(1);
            mac_valid_d = 1'b1;
            mac_sof_d   = 1'b1;
            mac_eof_d   = (lenq_head == 16'd1);
            sent_d      = 16'd1;
          end else begin
            out_state_d = StMIdle;
          end
        end else if (sent_q != n_q && (!mac_valid_q || mac_ready)) begin
          mac_data_d  = rd_byte;
          rptr_d      = rptr_q + ptr_t'(1);
          mac_valid_d = 1'b1;
          mac_sof_d   = (sent_q == 16'd0);
          mac_eof_d   = (sent_q + 16'd1 == n_q);
          sent_d      = sent_q + 16'd1;
        end
      end
      default: out_state_d = StMIdle;
    endcase
  end

  // Flow control looks at next-cycle occupancy so the registered txdstrdy never overcommits.
  always_comb begin
    wptr_d       = fifo_we ? wptr_q + ptr_t'(1) : wptr_q;
    lwptr_d      = lenq_push ? lwptr_q + lptr_t'(1) : lwptr_q;
    used_d       = wptr_d - rptr_d;
    lcnt_d       = lwptr_d - lrptr_d;
    txack_d      = (in_state_d != StIdle);
    txendframe_d = end_pulse;
    err_d        = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    txdstrdy_d   = (used_d <= ptr_t'(Depth - 3)) && (lcnt_d < lptr_t'(LenqDepth)) &&
                   (in_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_state_q   <= StIdle;
      out_state_q  <= StMIdle;
      txack_q      <= 1'b0;
      txdstrdy_q   <= 1'b0;
      txendframe_q <= 1'b0;
      len_q        <= 16'd0;
      cnt_q        <= 16'd0;
      ovr_q        <= 1'b0;
      err_q        <= 16'd0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      lwptr_q      <= '0;
      lrptr_q      <= '0;
      n_q          <= 16'd0;
      sent_q       <= 16'd0;
      mac_valid_q  <= 1'b0;
      mac_data_q   <= 8'd0;
      mac_sof_q    <= 1'b0;
      mac_eof_q    <= 1'b0;
      frame_q      <= 32'd0;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      txack_q      <= txack_d;
      txdstrdy_q   <= txdstrdy_d;
      txendframe_q <= txendframe_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      ovr_q        <= ovr_d;
      err_q        <= err_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      lwptr_q      <= lwptr_d;
      lrptr_q      <= lrptr_d;
      n_q          <= n_d;
      sent_q       <= sent_d;
      mac_valid_q  <= mac_valid_d;
      mac_data_q   <= mac_data_d;
      mac_sof_q    <= mac_sof_d;
      mac_eof_q    <= mac_eof_d;
      frame_q      <= frame_d;
    end
  end

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge clk) begin
    if (fifo_we) mem[wptr_q[DEPTH_LOG2-1:0]] <= txdata;
    if (lenq_push) lenq[lwptr_q[LENQ_LOG2-1:0]] <= cnt_d;
  end

  assign txack       = txack_q;
  assign txdstrdy    = txdstrdy_q;
  assign txendframe  = txendframe_q;
  assign mac_data    = mac_data_q;
  assign mac_valid   = mac_valid_q;
  assign mac_sof     = mac_sof_q;
  assign mac_eof     = mac_eof_q;
  assign frame_count = frame_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_udp_tx_frame_sink.sv
// Directed + randomized bench for udp_tx_frame_sink; expected MAC stream, counters and
// txendframe pulses come from a frame-level model of the length rules.
module tb_udp_tx_frame_sink;

  localparam int MaxLen = 4000;

  logic        clk, rstn, enable, txreq, txack, txstart, txstop, txdone;
  logic [7:0]  txdata;
  logic [15:0] txlength;
  logic        txdstrdy, txendframe;
  logic [7:0]  mac_data;
  logic        mac_valid, mac_ready, mac_sof, mac_eof;
  logic [31:0] frame_count;
  logic [15:0] err_count;

  udp_tx_frame_sink #(
    .DEPTH_LOG2(12),
    .MAX_LEN   (MaxLen),
    .LENQ_LOG2 (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .txreq      (txreq),
    .txack      (txack),
    .txstart    (txstart),
    .txstop     (txstop),
    .txdone     (txdone),
    .txdata     (txdata),
    .txlength   (txlength),
    .txdstrdy   (txdstrdy),
    .txendframe (txendframe),
    .mac_data   (mac_data),
    .mac_valid  (mac_valid),
    .mac_ready  (mac_ready),
    .mac_sof    (mac_sof),
    .mac_eof    (mac_eof),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
  int bytes_acc = 0;
  int exp_frames = 0, exp_err = 0, exp_endf = 0, endf_seen = 0;
  logic [9:0] exp_q[$];  // {sof, eof, data}

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  initial begin
    mac_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       mac_ready = 1'b1;
        1:       mac_ready = 1'b0;
        default: mac_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // MAC-side monitor: byte stream, hold-while-stalled and txendframe pulse count.
  initial begin
    logic       hold_pend;
    logic [9:0] hold_word;
    logic [9:0] w;
    hold_pend = 1'b0;
    hold_word = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend)
          check("mac_hold", {mac_valid, mac_sof, mac_eof, mac_data}, {1'b1, hold_word});
        hold_pend = mac_valid && !mac_ready;
        hold_word = {mac_sof, mac_eof, mac_data};
        if (txendframe) endf_seen++;
        if (mac_valid && mac_ready) begin
          check("mac_unexpected_byte", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("mac_byte", {mac_sof, mac_eof, mac_data}, w);
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_txack"}, txack, 0);
    check({tag, "_txdstrdy"}, txdstrdy, 0);
    check({tag, "_txendframe"}, txendframe, 0);
    check({tag, "_mac_valid"}, mac_valid, 0);
    check({tag, "_mac_sof_eof"}, {mac_sof, mac_eof}, 0);
    check({tag, "_mac_data"}, mac_data, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic grant();
    txreq = 1'b1;
    check("grant_pre", txack, 0);
    @(posedge clk);
    #1;
    txreq = 1'b0;
    check("grant_ack", txack, 1);
  endtask

  task automatic release_grant();
    txdone = 1'b1;
    @(posedge clk);
    #1;
    txdone = 1'b0;
    check("release_ack", txack, 0);
  endtask

  // Offers nsend bytes; a byte counts as taken only in a cycle where txdstrdy was high.
  task automatic send_frame(input int len, input int nsend, input bit with_stop, input bit ramp);
    logic [7:0] fb[$];
    logic       acc;
    int         i, stall, stored;
    i = 0;
    stall = 0;
    for (int k = 0; k < nsend; k++) fb.push_back(ramp ? 8'(k) : 8'($urandom_range(0, 255)));
    while (i < nsend && stall < 12000) begin
      txstart  = (i == 0);
      txstop   = with_stop && (i == nsend - 1);
      txdata   = fb[i];
      txlength = 16'(len);
      acc      = txdstrdy;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        bytes_acc++;
      end else begin
        stall++;
      end
    end
    txstart = 1'b0;
    txstop  = 1'b0;
    check("send_complete", i, nsend);
    if (with_stop) begin
      if (len >= 1 && len <= MaxLen) begin
        stored = (nsend < len) ? nsend : len;
        for (int k = 0; k < stored; k++) exp_q.push_back({k == 0, k == stored - 1, fb[k]});
        exp_frames++;
        if (nsend != len) exp_err++;
        if (nsend >= len) exp_endf++;
      end else begin
        exp_err++;
        exp_endf++;
      end
    end
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || mac_valid) && c < 30000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_frame_count"}, frame_count, exp_frames);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_endframe_pulses"}, endf_seen, exp_endf);
  endtask

  initial begin
    int base, fell, nf, len, nsend;
    rstn = 1'b0; enable = 1'b1; txreq = 1'b0; txstart = 1'b0; txstop = 1'b0;
    txdone = 1'b0; txdata = 8'd0; txlength = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // enable=0 blocks new grants
    enable = 1'b0;
    txreq  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_grant_disabled", txack, 0);
    txreq  = 1'b0;
    enable = 1'b1;

    // Basic 16-byte frame, latency and txendframe timing
    rdy_mode = 0;
    grant();
    send_frame(16, 16, 1'b1, 1'b1);
    check("basic_endframe_now", txendframe, 1);
    check("basic_lat1", mac_valid, 0);
    @(posedge clk);
    #1;
    check("basic_lat2", mac_valid, 0);
    @(posedge clk);
    #1;
    check("basic_lat3", {mac_valid, mac_sof, mac_data}, {1'b1, 1'b1, 8'h00});
    drain("basic");
    release_grant();

    // Backpressure: two max-length frames with the MAC stalled
    rdy_mode = 1;
    grant();
    send_frame(4000, 4000, 1'b1, 1'b0);
    base = bytes_acc;
    fork
      send_frame(4000, 4000, 1'b1, 1'b0);
      begin
        fell = 0;
        for (int c = 0; c < 400 && fell == 0; c++) begin
          @(posedge clk);
          #1;
          if (txdstrdy === 1'b0) fell = 1;
        end
        check("bp_dstrdy_fell", fell, 1);
        check("bp_before_full", (bytes_acc - base) inside {[90:96]}, 1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_still_stalled", {txdstrdy, mac_valid, mac_sof}, 3'b011);
        rdy_mode = 2;
      end
    join
    drain("backpressure");
    release_grant();

    // Short frame, then two rejects and an overrun within one grant
    rdy_mode = 0;
    grant();
    send_frame(10, 6, 1'b1, 1'b0);
    drain("short");
    send_frame(0, 3, 1'b1, 1'b0);
    check("reject0_back_in_grant", {txack, txdstrdy}, 2'b11);
    send_frame(MaxLen + 1, 5, 1'b1, 1'b0);
    check("reject_max_back_in_grant", {txack, txdstrdy}, 2'b11);
    drain("reject");
    send_frame(5, 8, 1'b1, 1'b0);
    drain("overrun");
    release_grant();

    // Three frames per grant with random MAC stalls
    rdy_mode = 2;
    grant();
    for (int f = 0; f < 3; f++) send_frame(5, 5, 1'b1, 1'b0);
    release_grant();
    drain("multi");

    // Randomized frames
    for (int g = 0; g < 8; g++) begin
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      grant();
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 64);
        case ($urandom_range(0, 3))
          0:       nsend = $urandom_range(1, len);
          1:       nsend = len + $urandom_range(1, 4);
          2:       begin len = 0; nsend = $urandom_range(1, 4); end
          default: nsend = len;
        endcase
        send_frame(len, nsend, 1'b1, 1'b0);
      end
      release_grant();
      drain("random");
    end

    // Reset in the middle of a frame
    rdy_mode = 0;
    grant();
    send_frame(8, 3, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    exp_frames = 0;
    exp_err    = 0;
    exp_endf   = 0;
    endf_seen  = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    grant();
    send_frame(8, 8, 1'b1, 1'b0);
    drain("after_reset");
    check("after_reset_one_frame", frame_count, 1);
    release_grant();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_frame_sink.md
Name: udp_tx_frame_sink

Overview:
- Consumer end of the event-builder TX handshake (txreq/txack/txstart/txstop/txdone, txdata, txlength, txdstrdy, txendframe).
- Grants the event builder access and paces incoming bytes with txdstrdy.
- Checks each frame against its announced length and stores frames in a byte FIFO.
- Forwards complete frames (store-and-forward) to the UDP/MAC transmit stream with sof/eof framing.
- Sits between the DAQ event builder and the Ethernet transmit path, in the clk125 domain.

Parameters:
- DEPTH_LOG2, 12: byte FIFO depth is 2^DEPTH_LOG2.
- MAX_LEN, 4000: largest legal txlength in bytes; must be ≤ 2^DEPTH_LOG2 - 4.
- LENQ_LOG2, 2: frame-length queue depth is 2^LENQ_LOG2 entries.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: asynchronous, active-low.
- enable  in  1  permit new grants.
- txreq  in  1  producer requests a transaction.
- txack  out  1  grant; held until txdone.
- txstart  in  1  pulse with the first byte of a frame.
- txstop  in  1  pulse with the last byte of a frame.
- txdone  in  1  pulse: transaction finished.
- txdata  in  8  payload byte.
- txlength  in  16  frame length; sampled on txstart.
- txdstrdy  out  1  sink can accept a byte this cycle.
- txendframe  out  1  one-cycle pulse: announced length reached or frame rejected.
- mac_data  out  8  output byte.
- mac_valid  out  1  output byte valid.
- mac_ready  in  1  downstream accepts the byte.
- mac_sof  out  1  first byte of a frame.
- mac_eof  out  1  last byte of a frame.
- frame_count  out  32  frames forwarded to MAC.
- err_count  out  16  length errors and rejects; saturates at 16'hFFFF.

Behaviour:
- Reset values: every output is 0. FIFO, length queue, both FSMs and the counters are cleared. Asserting rstn mid-frame discards all buffered data.
- Ingest FSM states: IDLE, GRANT, RECV, DROP.
  - IDLE -> GRANT when txreq & enable. txack is registered: it rises the cycle after entry and stays high in GRANT/RECV/DROP.
  - GRANT: txdone -> IDLE; txack drops the next cycle.
  - GRANT: txstart latches txlength as L and counts the start-cycle byte as byte 1.
    - If 1 ≤ L ≤ MAX_LEN -> RECV.
    - Otherwise -> DROP; err_count++.
- Byte acceptance: a byte is accepted in a cycle where (txstart in GRANT, or state RECV/DROP) and txdstrdy=1. Bytes offered while txdstrdy=0 are ignored; the producer must hold or pause.
- RECV: accepted bytes are written to the FIFO while count ≤ L.
  - Bytes beyond L are discarded and flag an overrun.
  - txendframe pulses the cycle after count reaches L.
  - On txstop, the frame is committed: the actual stored byte count is pushed to the length queue the next cycle, and the FSM returns to GRANT (multiple frames per grant are allowed).
  - If txstop arrives with count < L, or after an overrun, err_count increments once. The stored bytes are still forwarded; no extra txendframe is issued for a short frame.
- DROP: bytes are discarded, txendframe pulses once in the cycle after entry, and txstop -> GRANT.
- txstart and txstop in the same cycle means a one-byte frame.
- txdstrdy (registered) = 1 only when all of the following hold:
  - FIFO free space ≥ 3;
  - length queue not full;
  - state is GRANT, RECV or DROP.
- Output FSM states: M_IDLE, M_SEND.
  - M_IDLE -> M_SEND when the length queue is non-empty. The entry is popped as N; mac_valid rises the next cycle.
  - Byte transfer happens when mac_valid & mac_ready.
  - mac_data, mac_sof and mac_eof stay stable while mac_ready=0.
  - mac_sof is high with byte 1; mac_eof is high with byte N.
  - After the eof transfer: frame_count++. If the queue is non-empty, the next frame starts with no idle cycle; otherwise -> M_IDLE.
- Latency: the first mac_valid comes 3 cycles after the txstop cycle (commit +1, pop +1, read +1).
- Simultaneous FIFO write and read are supported. Pointers wrap modulo 2^DEPTH_LOG2. The FIFO never over- or underflows by construction.
- enable=0 blocks only new grants; an active grant completes normally.

Test Plan:
- Basic frame: txreq, then L=16 with bytes 0x00..0x0F and mac_ready=1 -> txack high from cycle+1; txendframe pulses once after byte 16; MAC emits 16 bytes with sof on 0x00 and eof on 0x0F; frame_count=1; err_count=0.
- Backpressure: L=4000 with mac_ready held 0 and then released -> txdstrdy falls before the FIFO fills; no bytes lost; MAC output equals input byte-for-byte.
- Short frame: L=10, txstop on byte 6 -> 6 bytes forwarded with eof on byte 6; err_count=1; no txendframe.
- Reject: L=0, then L=MAX_LEN+1 -> nothing forwarded; txendframe pulses once per frame; err_count=2; the FSM returns to GRANT each time.
- Multi-frame grant: three frames of L=5 within one grant, then txdone -> 15 MAC bytes in three sof/eof-delimited frames; txack falls one cycle after txdone.
- Reset mid-RECV: rstn low at byte 3 of L=8 -> all outputs 0; after release the next frame is forwarded cleanly and frame_count restarts from 0.
